// File: rtl/piso_pkg.sv
// piso_pkg -- shared definitions for the parallel-in/serial-out transmitter.
//
// Contents:
//   state_t    : transmitter FSM states (IDLE, SHIFT)
//   PARITY_EN  : 1 when the build appends an even-parity bit to every frame
//   frame_len  : serial bits per frame for a given data width
//   cnt_width  : width of the bit counter that spans one frame
//
// Configuration macro: PISO_PARITY_EN (defined = append even parity bit).
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_len(input int width);
    return PARITY_EN ? width + 1 : width;
  endfunction

  // The counter holds FRAME_LEN-1 down to 0; at least one bit wide.
  function automatic int cnt_width(input int width);
    int n;
    n = frame_len(width);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter -- loadable down-counter that tracks the bits left in a frame.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val (takes priority over en)
//   load_val : value to load, normally FRAME_LEN-1
//   en       : decrement by one; the count saturates at 0 and never wraps
//   last     : high while the count is 0 (last bit of the frame on the line)
module piso_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer -- parallel-in, serial-out transmitter.
//
// A WIDTH-bit word is accepted on the load_valid/load_ready handshake and sent
// one bit per shift_en cycle on sout, qualified by sout_valid. The first bit
// appears the cycle after acceptance. When the last bit is on the line and
// shift_en is high, load_ready is asserted so the next frame follows without
// a gap.
//
// Configuration macro: PISO_PARITY_EN -- when defined, an even-parity bit
// (XOR of the loaded word) is appended after the data bits.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, aborts any frame in flight
//   din        : parallel word to transmit
//   load_valid : source offers din
//   load_ready : a word can be accepted this cycle
//   shift_en   : advance sout this cycle; low holds the current bit
//   sout       : serial data bit
//   sout_valid : sout carries a frame bit
//   sout_first : first bit of a frame is on sout
//   frame_done : one-cycle pulse after the last bit of a frame is consumed
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             frame_done
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = cnt_width(WIDTH);

  state_t                 state, state_nxt;
  logic [FRAME_LEN-1:0]   shreg;
  logic [FRAME_LEN-1:0]   load_word;
  logic                   last;
  logic                   load_fire;
  logic                   advance;
  logic                   done_set;

  // Frame image laid out so the first bit to send sits at the output end.
`ifdef PISO_PARITY_EN
  logic parity;
  assign parity    = ^din;
  assign load_word = (MSB_FIRST != 0) ? {din, parity} : {parity, din};
`else
  assign load_word = din;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_fire) state_nxt = SHIFT;
      end
      SHIFT: begin
        // A load on the consuming edge of the last bit keeps us in SHIFT.
        if (last && shift_en && !load_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    load_ready = 1'b0;
    sout_valid = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        sout_valid = 1'b1;
        advance    = shift_en;
        load_ready = last && shift_en;
      end
      default: ;
    endcase
    load_fire = load_valid && load_ready;
    done_set  = advance && last;
  end

  piso_bit_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load_fire),
    .load_val (CNT_W'(FRAME_LEN - 1)),
    .en       (advance),
    .last     (last)
  );

  // Shift register: vacated positions fill with 0, so an idle line reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (load_fire) begin
      shreg <= load_word;
    end else if (advance) begin
      if (MSB_FIRST != 0) shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
      else                shreg <= {1'b0, shreg[FRAME_LEN-1:1]};
    end
  end

  assign sout = (MSB_FIRST != 0) ? shreg[FRAME_LEN-1] : shreg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sout_first <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_set;
      if (load_fire)    sout_first <= 1'b1;
      else if (advance) sout_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer -- checks two serializer instances (MSB-first and
// LSB-first) driven by the same stimulus against a queue-based model: each
// accepted word expands into a list of expected line bits, one bit leaves the
// list per consuming edge.
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  typedef struct packed {
    logic bm;     // bit value, MSB-first instance
    logic bl;     // bit value, LSB-first instance
    logic first;
    logic last;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             load_valid = 1'b0;
  logic             shift_en = 1'b0;

  logic ready_m, sout_m, valid_m, first_m, done_m;
  logic ready_l, sout_l, valid_l, first_l, done_l;

  ent_t q[$];
  logic done_exp = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(ready_m), .shift_en(shift_en), .sout(sout_m),
    .sout_valid(valid_m), .sout_first(first_m), .frame_done(done_m)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(ready_l), .shift_en(shift_en), .sout(sout_l),
    .sout_valid(valid_l), .sout_first(first_l), .frame_done(done_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] d);
    ent_t e;
    for (int i = 0; i < FLEN; i++) begin
      e.bm    = (i < WIDTH) ? d[WIDTH-1-i] : ^d;
      e.bl    = (i < WIDTH) ? d[i]         : ^d;
      e.first = (i == 0);
      e.last  = (i == FLEN - 1);
      q.push_back(e);
    end
  endtask

  // One clock: apply inputs, check outputs at the falling edge, then advance
  // the model across the rising edge.
  task automatic step(input logic r, input logic lv, input logic [WIDTH-1:0] d,
                      input logic se);
    logic ready_exp, busy;
    ent_t h;
    rst = r; load_valid = lv; din = d; shift_en = se;
    @(negedge clk);
    busy      = (q.size() != 0);
    h         = busy ? q[0] : '0;
    ready_exp = !busy || (q.size() == 1 && se);
    chk("load_ready_m", ready_m, ready_exp);
    chk("load_ready_l", ready_l, ready_exp);
    chk("sout_valid_m", valid_m, busy);
    chk("sout_valid_l", valid_l, busy);
    chk("sout_m", sout_m, h.bm);
    chk("sout_l", sout_l, h.bl);
    chk("sout_first_m", first_m, busy && h.first);
    chk("sout_first_l", first_l, busy && h.first);
    chk("frame_done_m", done_m, done_exp);
    chk("frame_done_l", done_l, done_exp);
    @(posedge clk);
    if (r) begin
      q.delete();
      done_exp = 1'b0;
    end else begin
      done_exp = 1'b0;
      if (busy && se) begin
        done_exp = h.last;
        void'(q.pop_front());
      end
      if (lv && ready_exp) push_frame(d);
    end
    #1;
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, WIDTH'($urandom), 1'b1);
  endtask

  initial begin
    // Bring both instances out of reset before the first comparison.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then basic frame A5 with shift_en held high.
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    idle_run(FLEN + 2);

    // Stall: two bits consumed, then three held cycles, then finish.
    step(1'b0, 1'b1, 8'h0F, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hFF, 1'b0);
    idle_run(FLEN + 2);

    // Back-to-back: FF then 00 with load_valid held.
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < FLEN; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
    idle_run(FLEN + 2);

    // Reset mid-frame, then a clean frame.
    step(1'b0, 1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h81, 1'b1);
    idle_run(FLEN + 2);

    // Parity-relevant words (plain frames when parity is off).
    step(1'b0, 1'b1, 8'h07, 1'b1);
    idle_run(FLEN + 1);

    // Random traffic with stalls, back-pressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 2) != 0),
           WIDTH'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    idle_run(FLEN + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
